// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the shared RAM port.
// slave = arbiter view, master = the surrounding requesters plus RAM model.
interface ram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]             rq_ren;
   logic [1:0]             rq_wen;
   logic [1:0][ADDR_W-1:0] rq_addr;
   logic [1:0][DATA_W-1:0] rq_store;
   logic [1:0]             rq_wait;
   logic [DATA_W-1:0]      rq_load;
   logic [1:0]             grant;
   logic                   ram_ren;
   logic                   ram_wen;
   logic [ADDR_W-1:0]      ram_addr;
   logic [DATA_W-1:0]      ram_store;
   logic [DATA_W-1:0]      ram_load;
   logic                   ram_ready;

   modport slave (
      input  rq_ren, rq_wen, rq_addr, rq_store, ram_load, ram_ready,
      output rq_wait, rq_load, grant, ram_ren, ram_wen, ram_addr, ram_store
   );

   modport master (
      output rq_ren, rq_wen, rq_addr, rq_store, ram_load, ram_ready,
      input  rq_wait, rq_load, grant, ram_ren, ram_wen, ram_addr, ram_store
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin RAM port arbiter with a burst lock of up to BURST_LEN words.
// Every grant is preceded by one IDLE cycle; rr_ptr moves only when a grant is released.
module ram_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 2
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.slave  arb_io
);
   localparam int CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

   typedef enum logic {IDLE, SERVE} state_e;

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   logic [1:0] req;
   logic       owner_idx;
   logic       owner_req;
   logic       release_now;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req[gi] = arb_io.rq_ren[gi] | arb_io.rq_wen[gi];
      end
   endgenerate

   // grant_q is one-hot, so bit 1 alone identifies the owner.
   assign owner_idx   = grant_q[1];
   assign owner_req   = req[owner_idx];
   assign release_now = !owner_req || (arb_io.ram_ready && (word_cnt_q == LAST_WORD));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= 2'b00;
         rr_ptr_q   <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      word_cnt_d = word_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d    = SERVE;
               word_cnt_d = '0;
               if (&req) grant_d = rr_ptr_q ? 2'b10 : 2'b01;
               else      grant_d = req;
            end
         end
         SERVE: begin
            // An abort drops the grant without counting a word, even if ram_ready is high.
            if (release_now) begin
               state_d    = IDLE;
               grant_d    = 2'b00;
               rr_ptr_d   = ~owner_idx;
               word_cnt_d = '0;
            end else if (arb_io.ram_ready) begin
               word_cnt_d = word_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      arb_io.ram_ren   = 1'b0;
      arb_io.ram_wen   = 1'b0;
      arb_io.ram_addr  = '0;
      arb_io.ram_store = '0;
      if (state_q == SERVE) begin
         arb_io.ram_addr  = arb_io.rq_addr[owner_idx];
         arb_io.ram_store = arb_io.rq_store[owner_idx];
         if (owner_req) begin
            arb_io.ram_wen = arb_io.rq_wen[owner_idx];
            arb_io.ram_ren = arb_io.rq_ren[owner_idx] & ~arb_io.rq_wen[owner_idx];
         end
      end
   end

   generate
      for (gi = 0; gi < 2; gi++) begin : g_wait
         assign arb_io.rq_wait[gi] = !((state_q == SERVE) && grant_q[gi] &&
                                       req[gi] && arb_io.ram_ready);
      end
   endgenerate

   assign arb_io.rq_load = arb_io.ram_load;
   assign arb_io.grant   = grant_q;

   a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
   a_grant_state:   assert property (@(posedge clk) disable iff (rst)
                                     (state_q == IDLE) == (grant_q == 2'b00));
endmodule
